// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath strobes; counts retired instructions.
// Latency: 3 cycles (branch/NOP), 4 (ALU, store), 5 (load) at zero-wait ack; each mem_ack wait adds one.
// Backpressure: holds in FETCH/MEM with mem_req high until mem_ack; start ignored while busy.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic [5:0]  opcode,
    input  logic [2:0]  branch,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  write_reg,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        alu_en,
    output logic        branch_en,
    output logic        reg_write,
    output logic        busy,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   store_q, store_d;
    logic   retire;

    // Control comes entirely from the decoded fields; the raw opcode is not needed here.
    logic unused_opcode;
    assign unused_opcode = ^opcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            if (retire)
                instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        retire    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        branch_en = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                // Branch outranks any memory flags, so a branch never reaches MEM.
                if (branch != 3'b000) begin
                    branch_en = 1'b1;
                    retire    = 1'b1;
                end else if (mem_read || mem_write) begin
                    state_d = S_MEM;
                    store_d = mem_write;
                end else if (write_reg != 2'b00) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (store_q)
                        retire = 1'b1;
                    else
                        state_d = S_WB;
                end
            end
            S_WB: retire = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (retire)
            state_d = halt_req ? S_HALT : S_FETCH;
    end

    // Store flag is latched on MEM entry so mem_we depends on registered state only.
    assign mem_req      = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_we       = (state_q == S_MEM) && store_q;
    assign mem_addr_sel = (state_q == S_MEM);
    assign alu_en       = (state_q == S_EXEC);
    assign reg_write    = (state_q == S_WB);
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted       = (state_q == S_HALT);
    assign state        = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: state walk, strobes and retire count per instruction class.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, halt_req;
    logic [5:0]  opcode;
    logic [2:0]  branch;
    logic        mem_read, mem_write;
    logic [1:0]  write_reg;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic        alu_en, branch_en, reg_write, busy, halted;
    logic [2:0]  state;
    logic [31:0] instr_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_cnt     = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .opcode(opcode), .branch(branch), .mem_read(mem_read),
        .mem_write(mem_write), .write_reg(write_reg), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .alu_en(alu_en),
        .branch_en(branch_en), .reg_write(reg_write), .busy(busy),
        .halted(halted), .state(state), .instr_count(instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [2:0] br, input logic rd, input logic wr, input logic [1:0] wreg);
        opcode    = 6'd0;
        branch    = br;
        mem_read  = rd;
        mem_write = wr;
        write_reg = wreg;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ack = 1'b0;
        set_instr(3'b000, 1'b0, 1'b0, 2'b00);
        tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_strobes", {29'd0, mem_req, busy, halted}, 32'd0);

        // ALU op, opcode 000000 with a register write: FETCH, DECODE, EXEC, WB
        rst = 1'b0; start = 1'b1; mem_ack = 1'b1;
        set_instr(3'b000, 1'b0, 1'b0, 2'b01);
        tick();
        start = 1'b0;
        check("alu_fetch_state", {29'd0, state}, 32'd1);
        check("alu_fetch_req", {29'd0, mem_req, mem_addr_sel, mem_we}, 32'b100);
        check("alu_fetch_irpc", {30'd0, ir_write, pc_write}, 32'b11);
        tick();
        check("alu_decode", {29'd0, state}, 32'd2);
        check("alu_decode_rw", {31'd0, reg_write}, 32'd0);
        tick();
        check("alu_exec", {29'd0, state}, 32'd3);
        check("alu_exec_alu_en", {31'd0, alu_en}, 32'd1);
        tick();
        check("alu_wb", {29'd0, state}, 32'd5);
        check("alu_wb_rw", {30'd0, reg_write, busy}, 32'b11);
        check("alu_wb_count", instr_count, 32'd0);
        tick(); exp_cnt = 1;
        check("alu_refetch", {29'd0, state}, 32'd1);
        check("alu_count", instr_count, exp_cnt);
        check("alu_rw_low", {31'd0, reg_write}, 32'd0);

        // lw with three wait cycles in MEM: 8 cycles total
        set_instr(3'b000, 1'b1, 1'b0, 2'b11);
        tick();
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ack = 1'b1;
            check("lw_mem_state", {29'd0, state}, 32'd4);
            check("lw_mem_ctl", {29'd0, mem_req, mem_addr_sel, mem_we}, 32'b110);
        end
        tick();
        check("lw_wb", {29'd0, state}, 32'd5);
        check("lw_wb_rw", {31'd0, reg_write}, 32'd1);
        tick(); exp_cnt = 2;
        check("lw_refetch", {29'd0, state}, 32'd1);
        check("lw_count", instr_count, exp_cnt);

        // sw with both memory flags: store wins, retires from MEM, no WB
        set_instr(3'b000, 1'b1, 1'b1, 2'b01);
        #1;
        check("sw_fetch_we", {31'd0, mem_we}, 32'd0);
        tick();
        tick();
        check("sw_exec", {29'd0, state}, 32'd3);
        tick();
        check("sw_mem", {29'd0, state}, 32'd4);
        check("sw_mem_ctl", {28'd0, mem_req, mem_addr_sel, mem_we, reg_write}, 32'b1110);
        tick(); exp_cnt = 3;
        check("sw_refetch", {29'd0, state}, 32'd1);
        check("sw_count", instr_count, exp_cnt);

        // branch with mem_write set: retires from EXEC, never enters MEM
        set_instr(3'b100, 1'b0, 1'b1, 2'b00);
        tick();
        check("br_decode_ben", {31'd0, branch_en}, 32'd0);
        tick();
        check("br_exec_ben", {30'd0, branch_en, alu_en}, 32'b11);
        tick(); exp_cnt = 4;
        check("br_refetch", {29'd0, state}, 32'd1);
        check("br_count", instr_count, exp_cnt);

        // halt_req pulse outside the retire cycle is lost
        set_instr(3'b000, 1'b0, 1'b0, 2'b00);
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick(); exp_cnt = 5;
        check("nop_halt_lost", {29'd0, state}, 32'd1);
        check("nop_count", instr_count, exp_cnt);

        // halt_req held: stop at the next boundary, stay until start
        halt_req = 1'b1;
        tick();
        tick();
        tick(); exp_cnt = 6;
        check("halt_state", {29'd0, state}, 32'd6);
        check("halt_flags", {29'd0, halted, busy, mem_req}, 32'b100);
        check("halt_count", instr_count, exp_cnt);
        tick();
        check("halt_hold", {29'd0, state}, 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0; halt_req = 1'b0;
        check("resume_state", {29'd0, state}, 32'd1);
        check("resume_count", instr_count, exp_cnt);

        // reset during a pending MEM wait, then a stray ack
        set_instr(3'b000, 1'b1, 1'b0, 2'b11);
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        check("rstmem_mem", {29'd0, state}, 32'd4);
        tick();
        rst = 1'b1;
        tick();
        check("rstmem_state", {29'd0, state}, 32'd0);
        check("rstmem_req", {31'd0, mem_req}, 32'd0);
        check("rstmem_count", instr_count, 32'd0);
        rst = 1'b0; mem_ack = 1'b1;
        tick();
        check("stray_ack_state", {29'd0, state}, 32'd0);
        check("stray_ack_ir", {30'd0, ir_write, pc_write}, 32'd0);

        // FETCH without ack holds with no IR/PC load; rst beats start
        mem_ack = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("fetch_wait_state", {29'd0, state}, 32'd1);
        check("fetch_wait_irpc", {29'd0, mem_req, ir_write, pc_write}, 32'b100);
        rst = 1'b1; start = 1'b1;
        tick();
        check("rst_over_start", {29'd0, state}, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
